// File: rtl/qpu_exu_dual_oitf_if.sv
// Dispatch/retire bus for the dual OITF: CF alloc/retire, MF alloc/retire, hazard query.
// master = EXU side driving requests, slave = the tracker.
interface qpu_exu_dual_oitf_if #(
  parameter int CF_DEPTH  = 4,
  parameter int MF_DEPTH  = 4,
  parameter int RFIDX_W   = 5,
  parameter int QUBIT_NUM = 8
);
  localparam int CF_CNT_W = $clog2(CF_DEPTH + 1);
  localparam int MF_CNT_W = $clog2(MF_DEPTH + 1);

  logic                 flush;

  logic                 cf_alc_ena;
  logic                 cf_alc_rdwen;
  logic [RFIDX_W-1:0]   cf_alc_rdidx;
  logic                 cf_ready;
  logic                 cf_ret_ena;
  logic                 cf_ret_rdwen;
  logic [RFIDX_W-1:0]   cf_ret_rdidx;
  logic                 cf_empty;
  logic [CF_CNT_W-1:0]  cf_count;

  logic                 mf_alc_ena;
  logic [QUBIT_NUM-1:0] mf_alc_ql;
  logic                 mf_ready;
  logic                 mf_ret_ena;
  logic [QUBIT_NUM-1:0] mf_ret_ql;
  logic                 mf_empty;
  logic [MF_CNT_W-1:0]  mf_count;

  logic                 disp_rs1en;
  logic                 disp_rs2en;
  logic                 disp_rdwen;
  logic [RFIDX_W-1:0]   disp_rs1idx;
  logic [RFIDX_W-1:0]   disp_rs2idx;
  logic [RFIDX_W-1:0]   disp_rdidx;
  logic                 disp_qfren;
  logic [QUBIT_NUM-1:0] disp_ql;

  logic                 match_rs1;
  logic                 match_rs2;
  logic                 match_rd;
  logic                 match_ql;

  modport master (
    output flush,
    output cf_alc_ena, cf_alc_rdwen, cf_alc_rdidx, cf_ret_ena,
    input  cf_ready, cf_ret_rdwen, cf_ret_rdidx, cf_empty, cf_count,
    output mf_alc_ena, mf_alc_ql, mf_ret_ena,
    input  mf_ready, mf_ret_ql, mf_empty, mf_count,
    output disp_rs1en, disp_rs2en, disp_rdwen, disp_rs1idx, disp_rs2idx, disp_rdidx,
    output disp_qfren, disp_ql,
    input  match_rs1, match_rs2, match_rd, match_ql
  );

  modport slave (
    input  flush,
    input  cf_alc_ena, cf_alc_rdwen, cf_alc_rdidx, cf_ret_ena,
    output cf_ready, cf_ret_rdwen, cf_ret_rdidx, cf_empty, cf_count,
    input  mf_alc_ena, mf_alc_ql, mf_ret_ena,
    output mf_ready, mf_ret_ql, mf_empty, mf_count,
    input  disp_rs1en, disp_rs2en, disp_rdwen, disp_rs1idx, disp_rs2idx, disp_rdidx,
    input  disp_qfren, disp_ql,
    output match_rs1, match_rs2, match_rd, match_ql
  );
endinterface

// File: rtl/qpu_exu_dual_oitf.sv
// Dual outstanding-instruction tracker (CF: rd writes, MF: measured qubits); alloc visible next cycle,
// retire/match combinational. Alloc backpressured by registered full (no retire bypass); flush clears both.
module qpu_exu_dual_oitf #(
  parameter int CF_DEPTH  = 4,
  parameter int MF_DEPTH  = 4,
  parameter int RFIDX_W   = 5,
  parameter int QUBIT_NUM = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  qpu_exu_dual_oitf_if.slave   bus
);
  localparam int CF_PTR_W = $clog2(CF_DEPTH);
  localparam int MF_PTR_W = $clog2(MF_DEPTH);
  localparam int CF_CNT_W = $clog2(CF_DEPTH + 1);
  localparam int MF_CNT_W = $clog2(MF_DEPTH + 1);

  // ---------------- classical FIFO ----------------
  logic [CF_DEPTH-1:0] cf_vld;
  logic [CF_DEPTH-1:0] cf_vld_nxt;
  logic [CF_DEPTH-1:0] cf_rdwen;
  logic [RFIDX_W-1:0]  cf_rdidx [CF_DEPTH];
  logic [CF_PTR_W-1:0] cf_wr_ptr;
  logic [CF_PTR_W-1:0] cf_rd_ptr;
  logic [CF_CNT_W-1:0] cf_cnt;
  logic                cf_full;
  logic                cf_emp;
  logic                cf_alc_acc;
  logic                cf_ret_acc;

  assign cf_full    = (cf_cnt == CF_CNT_W'(CF_DEPTH));
  assign cf_emp     = (cf_cnt == '0);
  assign cf_alc_acc = bus.cf_alc_ena && !cf_full;
  assign cf_ret_acc = bus.cf_ret_ena && !cf_emp;

  always_comb begin
    cf_vld_nxt = cf_vld;
    if (cf_alc_acc) cf_vld_nxt[cf_wr_ptr] = 1'b1;
    if (cf_ret_acc) cf_vld_nxt[cf_rd_ptr] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf_vld    <= '0;
      cf_rdwen  <= '0;
      for (int i = 0; i < CF_DEPTH; i++) cf_rdidx[i] <= '0;
      cf_wr_ptr <= '0;
      cf_rd_ptr <= '0;
      cf_cnt    <= '0;
    end else if (bus.flush) begin
      cf_vld    <= '0;
      cf_wr_ptr <= '0;
      cf_rd_ptr <= '0;
      cf_cnt    <= '0;
    end else begin
      cf_vld <= cf_vld_nxt;
      if (cf_alc_acc) begin
        cf_rdwen[cf_wr_ptr] <= bus.cf_alc_rdwen;
        cf_rdidx[cf_wr_ptr] <= bus.cf_alc_rdidx;
        cf_wr_ptr <= (cf_wr_ptr == CF_PTR_W'(CF_DEPTH - 1)) ? '0 : cf_wr_ptr + CF_PTR_W'(1);
      end
      if (cf_ret_acc)
        cf_rd_ptr <= (cf_rd_ptr == CF_PTR_W'(CF_DEPTH - 1)) ? '0 : cf_rd_ptr + CF_PTR_W'(1);
      case ({cf_alc_acc, cf_ret_acc})
        2'b10:   cf_cnt <= cf_cnt + CF_CNT_W'(1);
        2'b01:   cf_cnt <= cf_cnt - CF_CNT_W'(1);
        default: cf_cnt <= cf_cnt;
      endcase
    end
  end

  // ---------------- measurement FIFO ----------------
  logic [MF_DEPTH-1:0]  mf_vld;
  logic [MF_DEPTH-1:0]  mf_vld_nxt;
  logic [QUBIT_NUM-1:0] mf_ql [MF_DEPTH];
  logic [MF_PTR_W-1:0]  mf_wr_ptr;
  logic [MF_PTR_W-1:0]  mf_rd_ptr;
  logic [MF_CNT_W-1:0]  mf_cnt;
  logic                 mf_full;
  logic                 mf_emp;
  logic                 mf_alc_acc;
  logic                 mf_ret_acc;

  assign mf_full    = (mf_cnt == MF_CNT_W'(MF_DEPTH));
  assign mf_emp     = (mf_cnt == '0);
  assign mf_alc_acc = bus.mf_alc_ena && !mf_full;
  assign mf_ret_acc = bus.mf_ret_ena && !mf_emp;

  always_comb begin
    mf_vld_nxt = mf_vld;
    if (mf_alc_acc) mf_vld_nxt[mf_wr_ptr] = 1'b1;
    if (mf_ret_acc) mf_vld_nxt[mf_rd_ptr] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mf_vld    <= '0;
      for (int i = 0; i < MF_DEPTH; i++) mf_ql[i] <= '0;
      mf_wr_ptr <= '0;
      mf_rd_ptr <= '0;
      mf_cnt    <= '0;
    end else if (bus.flush) begin
      mf_vld    <= '0;
      mf_wr_ptr <= '0;
      mf_rd_ptr <= '0;
      mf_cnt    <= '0;
    end else begin
      mf_vld <= mf_vld_nxt;
      if (mf_alc_acc) begin
        mf_ql[mf_wr_ptr] <= bus.mf_alc_ql;
        mf_wr_ptr <= (mf_wr_ptr == MF_PTR_W'(MF_DEPTH - 1)) ? '0 : mf_wr_ptr + MF_PTR_W'(1);
      end
      if (mf_ret_acc)
        mf_rd_ptr <= (mf_rd_ptr == MF_PTR_W'(MF_DEPTH - 1)) ? '0 : mf_rd_ptr + MF_PTR_W'(1);
      case ({mf_alc_acc, mf_ret_acc})
        2'b10:   mf_cnt <= mf_cnt + MF_CNT_W'(1);
        2'b01:   mf_cnt <= mf_cnt - MF_CNT_W'(1);
        default: mf_cnt <= mf_cnt;
      endcase
    end
  end

  // ---------------- hazard match (registered valid only) ----------------
  logic hit_rs1, hit_rs2, hit_rd, hit_ql;

  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    hit_rd  = 1'b0;
    for (int i = 0; i < CF_DEPTH; i++) begin
      // x0 is never a real destination, so it can never create a hazard
      if (cf_vld[i] && cf_rdwen[i] && (cf_rdidx[i] != '0)) begin
        if (cf_rdidx[i] == bus.disp_rs1idx) hit_rs1 = 1'b1;
        if (cf_rdidx[i] == bus.disp_rs2idx) hit_rs2 = 1'b1;
        if (cf_rdidx[i] == bus.disp_rdidx)  hit_rd  = 1'b1;
      end
    end
  end

  always_comb begin
    hit_ql = 1'b0;
    for (int i = 0; i < MF_DEPTH; i++)
      if (mf_vld[i] && (|(mf_ql[i] & bus.disp_ql))) hit_ql = 1'b1;
  end

  assign bus.match_rs1 = bus.disp_rs1en && hit_rs1;
  assign bus.match_rs2 = bus.disp_rs2en && hit_rs2;
  assign bus.match_rd  = bus.disp_rdwen && hit_rd;
  assign bus.match_ql  = bus.disp_qfren && hit_ql;

  // ---------------- status / head outputs ----------------
  assign bus.cf_ready     = !cf_full;
  assign bus.cf_empty     = cf_emp;
  assign bus.cf_count     = cf_cnt;
  assign bus.cf_ret_rdwen = cf_emp ? 1'b0 : cf_rdwen[cf_rd_ptr];
  assign bus.cf_ret_rdidx = cf_emp ? '0   : cf_rdidx[cf_rd_ptr];

  assign bus.mf_ready     = !mf_full;
  assign bus.mf_empty     = mf_emp;
  assign bus.mf_count     = mf_cnt;
  assign bus.mf_ret_ql    = mf_emp ? '0   : mf_ql[mf_rd_ptr];
endmodule
